// File: rtl/srio_pkg.sv
// Shared constants for the SRIO SWRITE pack/unpack blocks: FSM encodings,
// command-word bit positions and SWRITE header field widths.
package srio_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARB     = 2'd1;
   localparam logic [1:0] ST_HDR     = 2'd2;
   localparam logic [1:0] ST_PAYLOAD = 2'd3;

   localparam int CMD_START = 0;
   localparam int CMD_RESET = 1;
   localparam int CMD_EN0   = 2;
   localparam int CMD_EN1   = 3;

   localparam int SW_HDR_W   = 64;
   localparam int SW_ADDR_W  = 32;
   localparam int SW_UPPER_W = SW_HDR_W - SW_ADDR_W;

   function automatic logic [SW_HDR_W-1:0] build_hdr(input logic [SW_UPPER_W-1:0] upper,
                                                     input logic [SW_ADDR_W-1:0]  addr);
      return {upper, addr};
   endfunction

endpackage

// File: rtl/srio_rr_arb2.sv
// Two-requester round-robin arbiter. The last-grant register only moves when
// en_i strobes with a live request, so the caller decides when a grant is taken.
module srio_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic       gnt_o,
   output logic       gnt_vld_o
);

   logic last_q, last_d;

   // On contention the requester that did not win last time goes first.
   assign gnt_o     = (&req_i) ? ~last_q : req_i[1];
   assign gnt_vld_o = |req_i;
   assign last_d    = (en_i && gnt_vld_o) ? gnt_o : last_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/srio_swrite_pack_arb.sv
// Shares one SRIO SWRITE egress stream between two branch sources: per packet it
// inserts a 64-bit header carrying the branch address, then passes payload through.
module srio_swrite_pack_arb
   import srio_pkg::*;
#(
   parameter logic [31:0] HDR_UPPER = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             AXIS_ACLK,
   input  logic             AXIS_ARESETN,
   input  logic [63:0]      S0_AXIS_TDATA,
   input  logic             S0_AXIS_TVALID,
   input  logic             S0_AXIS_TLAST,
   output logic             S0_AXIS_TREADY,
   input  logic [63:0]      S1_AXIS_TDATA,
   input  logic             S1_AXIS_TVALID,
   input  logic             S1_AXIS_TLAST,
   output logic             S1_AXIS_TREADY,
   output logic [63:0]      M_AXIS_TDATA,
   output logic             M_AXIS_TVALID,
   output logic             M_AXIS_TLAST,
   input  logic             M_AXIS_TREADY,
   input  logic [31:0]      cmd,
   input  logic [31:0]      addr_0,
   input  logic [31:0]      addr_1,
   output logic [CNT_W-1:0] pkt_cnt_0,
   output logic [CNT_W-1:0] pkt_cnt_1,
   output logic             busy
);

   logic [1:0]       state_q, state_d;
   logic             grant_q, grant_d;
   logic [63:0]      hdr_q, hdr_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [1:0]       req;
   logic             arb_en, arb_gnt, arb_vld;
   logic             m_xfr;
   logic             cmd_unused;

   assign cmd_unused = ^cmd[31:4];

   assign req    = {S1_AXIS_TVALID & cmd[CMD_EN1], S0_AXIS_TVALID & cmd[CMD_EN0]};
   assign arb_en = (state_q == ST_ARB) && !cmd[CMD_RESET];

   srio_rr_arb2 u_arb (
      .clk_i     (AXIS_ACLK),
      .rst_ni    (AXIS_ARESETN),
      .req_i     (req),
      .en_i      (arb_en),
      .gnt_o     (arb_gnt),
      .gnt_vld_o (arb_vld)
   );

   // Output steering: header beat from the register, payload straight from the granted branch.
   always_comb begin
      M_AXIS_TDATA   = '0;
      M_AXIS_TVALID  = 1'b0;
      M_AXIS_TLAST   = 1'b0;
      S0_AXIS_TREADY = 1'b0;
      S1_AXIS_TREADY = 1'b0;
      case (state_q)
         ST_HDR: begin
            M_AXIS_TDATA  = hdr_q;
            M_AXIS_TVALID = 1'b1;
         end
         ST_PAYLOAD: begin
            if (grant_q) begin
               M_AXIS_TDATA   = S1_AXIS_TDATA;
               M_AXIS_TVALID  = S1_AXIS_TVALID;
               M_AXIS_TLAST   = S1_AXIS_TLAST;
               S1_AXIS_TREADY = M_AXIS_TREADY;
            end else begin
               M_AXIS_TDATA   = S0_AXIS_TDATA;
               M_AXIS_TVALID  = S0_AXIS_TVALID;
               M_AXIS_TLAST   = S0_AXIS_TLAST;
               S0_AXIS_TREADY = M_AXIS_TREADY;
            end
         end
         default: ;
      endcase
   end

   assign m_xfr = M_AXIS_TVALID & M_AXIS_TREADY;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      hdr_d   = hdr_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      if (state_q == ST_PAYLOAD && m_xfr && M_AXIS_TLAST) begin
         if (grant_q) cnt1_d = cnt1_q + CNT_W'(1);
         else         cnt0_d = cnt0_q + CNT_W'(1);
      end
      // The reset command overrides every transition; counters are left alone.
      if (cmd[CMD_RESET]) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (cmd[CMD_START]) state_d = ST_ARB;
            ST_ARB: begin
               if (arb_vld) begin
                  grant_d = arb_gnt;
                  hdr_d   = build_hdr(HDR_UPPER, arb_gnt ? addr_1 : addr_0);
                  state_d = ST_HDR;
               end
            end
            ST_HDR:     if (m_xfr) state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (m_xfr && M_AXIS_TLAST) state_d = ST_ARB;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         hdr_q   <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         hdr_q   <= hdr_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign pkt_cnt_0 = cnt0_q;
   assign pkt_cnt_1 = cnt1_q;
   assign busy      = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_srio_swrite_pack_arb.sv
// Bench for srio_swrite_pack_arb: directed phases with random payloads and
// back-pressure, checked against a packet-level round-robin reference model.
module tb_srio_swrite_pack_arb;

   localparam logic [31:0] TB_HDR_UPPER = 32'h0000_0000;
   localparam int          TB_CNT_W     = 4;  // narrow so counter wrap is reachable

   logic                AXIS_ACLK = 1'b0;
   logic                AXIS_ARESETN;
   logic [63:0]         S0_AXIS_TDATA, S1_AXIS_TDATA, M_AXIS_TDATA;
   logic                S0_AXIS_TVALID, S0_AXIS_TLAST, S0_AXIS_TREADY;
   logic                S1_AXIS_TVALID, S1_AXIS_TLAST, S1_AXIS_TREADY;
   logic                M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
   logic [31:0]         cmd, addr_0, addr_1;
   logic [TB_CNT_W-1:0] pkt_cnt_0, pkt_cnt_1;
   logic                busy;

   srio_swrite_pack_arb #(.HDR_UPPER(TB_HDR_UPPER), .CNT_W(TB_CNT_W)) dut (
      .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESETN(AXIS_ARESETN),
      .S0_AXIS_TDATA(S0_AXIS_TDATA), .S0_AXIS_TVALID(S0_AXIS_TVALID),
      .S0_AXIS_TLAST(S0_AXIS_TLAST), .S0_AXIS_TREADY(S0_AXIS_TREADY),
      .S1_AXIS_TDATA(S1_AXIS_TDATA), .S1_AXIS_TVALID(S1_AXIS_TVALID),
      .S1_AXIS_TLAST(S1_AXIS_TLAST), .S1_AXIS_TREADY(S1_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
      .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
      .cmd(cmd), .addr_0(addr_0), .addr_1(addr_1),
      .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .busy(busy)
   );

   always #5 AXIS_ACLK = ~AXIS_ACLK;

   // Source queues hold {tlast, tdata}; exp_q is the expected egress stream.
   logic [64:0] s_q0[$], s_q1[$], exp_q[$];
   int          n_vec = 0, n_err = 0;
   int          exp_cnt0 = 0, exp_cnt1 = 0, m_beats = 0;
   logic        model_last = 1'b1;
   bit          rand_ready = 0;
   bit          hdr_due = 0, prev_last_xfr = 0, prev_stall = 0;
   logic [64:0] prev_beat = '0;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      logic [64:0] obs, e;
      logic        m_xfr;
      obs   = {M_AXIS_TLAST, M_AXIS_TDATA};
      m_xfr = M_AXIS_TVALID & M_AXIS_TREADY;
      if (hdr_due) chk("hdr_latency", 65'(M_AXIS_TVALID), 65'(1));
      hdr_due = 0;
      if (prev_last_xfr) begin
         chk("arb_gap", 65'(M_AXIS_TVALID), 65'(0));
         hdr_due = ((S0_AXIS_TVALID && cmd[2]) || (S1_AXIS_TVALID && cmd[3])) && !cmd[1];
      end
      if (prev_stall) begin
         chk("stall_valid", 65'(M_AXIS_TVALID), 65'(1));
         chk("stall_beat", obs, prev_beat);
      end
      chk("ready_excl", 65'(S0_AXIS_TREADY & S1_AXIS_TREADY), 65'(0));
      if (m_xfr) begin
         m_beats++;
         chk("beat_expected", 65'(exp_q.size() > 0), 65'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_beat", obs, e);
         end
      end
      if (S0_AXIS_TVALID && S0_AXIS_TREADY) begin
         chk("s0_pass", 65'(m_xfr), 65'(1));
         void'(s_q0.pop_front());
      end
      if (S1_AXIS_TVALID && S1_AXIS_TREADY) begin
         chk("s1_pass", 65'(m_xfr), 65'(1));
         void'(s_q1.pop_front());
      end
      prev_last_xfr = m_xfr && M_AXIS_TLAST;
      prev_stall    = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_beat     = obs;
   endtask

   task automatic cycle();
      @(negedge AXIS_ACLK);
      S0_AXIS_TVALID = s_q0.size() > 0;
      {S0_AXIS_TLAST, S0_AXIS_TDATA} = (s_q0.size() > 0) ? s_q0[0] : 65'(0);
      S1_AXIS_TVALID = s_q1.size() > 0;
      {S1_AXIS_TLAST, S1_AXIS_TDATA} = (s_q1.size() > 0) ? s_q1[0] : 65'(0);
      M_AXIS_TREADY = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      monitor();
   endtask

   // Reference: every packet queued up front, sources never idle between packets,
   // so egress order is pure packet round robin starting after model_last.
   task automatic load_batch(input int n0, input int n1, input int minlen, input int maxlen);
      logic [64:0] b0[$], b1[$];
      logic [64:0] b;
      int          l0[$], l1[$];
      int          len;
      logic        ch;
      for (int p = 0; p < n0 + n1; p++) begin
         len = $urandom_range(maxlen, minlen);
         for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), $urandom(), $urandom()};
            if (p < n0) begin s_q0.push_back(b); b0.push_back(b); end
            else        begin s_q1.push_back(b); b1.push_back(b); end
         end
         if (p < n0) l0.push_back(len); else l1.push_back(len);
      end
      while (l0.size() > 0 || l1.size() > 0) begin
         ch = (l0.size() > 0 && l1.size() > 0) ? ~model_last : (l1.size() > 0);
         exp_q.push_back({1'b0, TB_HDR_UPPER, ch ? addr_1 : addr_0});
         len = ch ? l1.pop_front() : l0.pop_front();
         repeat (len) exp_q.push_back(ch ? b1.pop_front() : b0.pop_front());
         model_last = ch;
         if (ch) exp_cnt1++; else exp_cnt0++;
      end
   endtask

   task automatic run_drain(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || s_q0.size() > 0 || s_q1.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", 65'(n < budget), 65'(1));
      cycle();  // lands in ARB after the final TLAST
      cmd = 32'h2;
      cycle();
      cmd = 32'h0;
      s_q0.delete(); s_q1.delete(); exp_q.delete();
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_cnt0"}, 65'(pkt_cnt_0), 65'(exp_cnt0 % (1 << TB_CNT_W)));
      chk({tag, "_cnt1"}, 65'(pkt_cnt_1), 65'(exp_cnt1 % (1 << TB_CNT_W)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      AXIS_ARESETN = 1'b0;
      cmd = 32'h1; addr_0 = 32'h1000; addr_1 = 32'h2000;
      M_AXIS_TREADY = 1'b1;
      S0_AXIS_TVALID = 1'b1; S0_AXIS_TLAST = 1'b1; S0_AXIS_TDATA = 64'h1234;
      S1_AXIS_TVALID = 1'b1; S1_AXIS_TLAST = 1'b1; S1_AXIS_TDATA = 64'h5678;

      // Reset state: everything low even with live inputs.
      repeat (2) @(negedge AXIS_ACLK);
      #1;
      chk("rst_m_valid", 65'(M_AXIS_TVALID), 65'(0));
      chk("rst_m_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, 65'(0));
      chk("rst_s0_ready", 65'(S0_AXIS_TREADY), 65'(0));
      chk("rst_s1_ready", 65'(S1_AXIS_TREADY), 65'(0));
      chk("rst_busy", 65'(busy), 65'(0));
      chk_counts("rst");
      cmd = 32'h0;
      cycle();
      AXIS_ARESETN = 1'b1;
      cycle();
      chk("idle_valid", 65'(M_AXIS_TVALID), 65'(0));

      // Phase 1: ch0 only, addr 0x1000, 4-beat packet, header 1 cycle after TVALID.
      cmd = 32'h5; addr_0 = 32'h1000;
      repeat (3) cycle();
      chk("arb_busy", 65'(busy), 65'(0));
      load_batch(1, 0, 4, 4);
      cycle();
      chk("arb_s0_ready", 65'(S0_AXIS_TREADY), 65'(0));
      chk("arb_m_valid", 65'(M_AXIS_TVALID), 65'(0));
      cycle();
      chk("p1_hdr_valid", 65'(M_AXIS_TVALID), 65'(1));
      chk("p1_hdr_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, 65'h0_0000_0000_0000_1000);
      chk("p1_busy", 65'(busy), 65'(1));
      run_drain(100);
      chk_counts("p1");

      // Phase 2: both channels, 3-beat packets, full throughput, alternating grants.
      cmd = 32'hD; addr_0 = 32'h2000_0000; addr_1 = 32'h3000_0004;
      load_batch(4, 4, 3, 3);
      run_drain(200);
      chk_counts("p2");

      // Phase 3: random back-pressure, random lengths and addresses.
      rand_ready = 1;
      addr_0 = $urandom(); addr_1 = $urandom();
      cmd = 32'hD;
      load_batch(10, 10, 1, 8);
      run_drain(2000);
      chk_counts("p3");
      rand_ready = 0;

      // Phase 4: single-beat packet on ch1 gives exactly two egress beats.
      addr_1 = 32'hABCD; m_beats = 0;
      cmd = 32'h9;
      load_batch(0, 1, 1, 1);
      run_drain(50);
      chk("p4_beats", 65'(m_beats), 65'(2));
      chk_counts("p4");

      // Phase 5: reset command during payload beat 2 of 6 truncates the packet.
      addr_0 = 32'h0000_5A5A; m_beats = 0;
      cmd = 32'h5;
      load_batch(1, 0, 6, 6);
      exp_cnt0--;  // this packet never completes
      for (int n = 0; n < 50 && m_beats < 3; n++) cycle();
      chk("p5_reached_beat2", 65'(m_beats), 65'(3));
      cmd = 32'h6;
      cycle();
      cmd = 32'h0;
      chk("p5_m_valid", 65'(M_AXIS_TVALID), 65'(0));
      chk("p5_s0_ready", 65'(S0_AXIS_TREADY), 65'(0));
      chk("p5_s1_ready", 65'(S1_AXIS_TREADY), 65'(0));
      chk("p5_busy", 65'(busy), 65'(0));
      chk_counts("p5_abort");
      s_q0.delete(); exp_q.delete();
      repeat (2) cycle();
      chk("p5_idle_valid", 65'(M_AXIS_TVALID), 65'(0));
      cmd = 32'h5;
      load_batch(1, 0, 2, 2);
      run_drain(50);
      chk_counts("p5_restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
